button_event_queue: RTL and testbench

- Sits directly downstream of the per-button debouncers, consuming their clean level outputs.
- Turns each complete press/release of a button into one event, tagged with the button index and a short/long-hold flag.
- Buffers events in a small FIFO.
- The Simon game controller pops events with a valid/ready handshake, so no press is lost while the game is busy (playing a tone, updating the LCD).

---
 rtl/button_event_queue.sv | 184 ++++++++++++++++++
 tb/tb_button_event_queue.sv | 173 +++++++++++++++++
 2 files changed

// File: rtl/button_event_queue.sv
// Purpose: turn debounced button press/release pairs into {button, long} events queued for the game controller.
// Latency: release sampled at edge E0 sets a pending bit; the event is pushed and visible on evt_valid after E1.
// Backpressure: evt_valid/evt_ready pop; a full FIFO holds events in per-button pending bits, and a second release while pending is dropped.
module button_event_queue #(
    parameter int NUM_BTN           = 4,
    parameter int LONG_PRESS_CYCLES = 100_000_000,
    parameter int FIFO_DEPTH        = 8
) (
    input  logic                          clock,
    input  logic                          reset,
    input  logic [NUM_BTN-1:0]            btn_db,
    input  logic                          enable,
    input  logic                          flush,
    input  logic                          evt_ready,
    output logic                          evt_valid,
    output logic [$clog2(NUM_BTN)-1:0]    evt_btn,
    output logic                          evt_long,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
    output logic                          overflow
);
    localparam int BW = $clog2(NUM_BTN);
    localparam int CW = $clog2(LONG_PRESS_CYCLES + 1);
    localparam logic [CW-1:0] CNT_MAX = CW'(LONG_PRESS_CYCLES);

    logic [NUM_BTN-1:0] btn_prev;
    logic [NUM_BTN-1:0] armed;
    logic [NUM_BTN-1:0] pending;
    logic [NUM_BTN-1:0] plong;
    logic [CW-1:0]      cnt [NUM_BTN];

    logic               arb_vld;
    logic [BW-1:0]      arb_idx;
    logic               fifo_wr_rdy;
    logic               push_fire;
    logic [BW:0]        push_dat;
    logic [BW:0]        head_dat;

    // Fixed priority: lowest-index pending button wins the single push slot.
    always_comb begin
        arb_vld = 1'b0;
        arb_idx = '0;
        for (int i = NUM_BTN - 1; i >= 0; i--) begin
            if (pending[i]) begin
                arb_vld = 1'b1;
                arb_idx = BW'(i);
            end
        end
    end

    assign push_dat  = {arb_idx, plong[arb_idx]};
    assign push_fire = arb_vld & fifo_wr_rdy & ~flush;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            btn_prev <= '1;
            armed    <= '0;
            pending  <= '0;
            plong    <= '0;
            overflow <= 1'b0;
            for (int i = 0; i < NUM_BTN; i++) begin
                cnt[i] <= '0;
            end
        end else begin
            btn_prev <= btn_db;
            if (flush) begin
                armed    <= '0;
                pending  <= '0;
                plong    <= '0;
                overflow <= 1'b0;
                for (int i = 0; i < NUM_BTN; i++) begin
                    cnt[i] <= '0;
                end
            end else begin
                for (int i = 0; i < NUM_BTN; i++) begin
                    if (push_fire && (arb_idx == BW'(i))) begin
                        pending[i] <= 1'b0;
                    end
                    if (btn_db[i] && !btn_prev[i]) begin
                        armed[i] <= enable;
                        if (enable) begin
                            cnt[i] <= CW'(1);
                        end
                    end else if (btn_db[i] && armed[i]) begin
                        if (cnt[i] < CNT_MAX) begin
                            cnt[i] <= cnt[i] + CW'(1);
                        end
                    end else if (!btn_db[i] && btn_prev[i] && armed[i]) begin
                        // Unarmed falls (held through reset, pressed while disabled) never reach here.
                        armed[i] <= 1'b0;
                        if (pending[i]) begin
                            overflow <= 1'b1;
                        end else begin
                            pending[i] <= 1'b1;
                            plong[i]   <= (cnt[i] >= CNT_MAX);
                        end
                    end
                end
            end
        end
    end

    sync_fifo #(
        .WIDTH (BW + 1),
        .DEPTH (FIFO_DEPTH)
    ) u_evt_fifo (
        .clock  (clock),
        .reset  (reset),
        .flush  (flush),
        .wr_vld (arb_vld),
        .wr_rdy (fifo_wr_rdy),
        .wr_dat (push_dat),
        .rd_vld (evt_valid),
        .rd_rdy (evt_ready),
        .rd_dat (head_dat),
        .level  (fifo_level)
    );

    assign evt_btn  = head_dat[BW:1];
    assign evt_long = head_dat[0];

endmodule

// Purpose: generic show-ahead FIFO with occupancy count and synchronous flush.
// Latency: a write is visible on rd_dat the cycle after it is accepted; rd_dat reads 0 when empty.
// Backpressure: wr_rdy drops when full (checked before any same-cycle read); read pops on rd_vld & rd_rdy.
module sync_fifo #(
    parameter int WIDTH = 3,
    parameter int DEPTH = 8
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     flush,
    input  logic                     wr_vld,
    output logic                     wr_rdy,
    input  logic [WIDTH-1:0]         wr_dat,
    output logic                     rd_vld,
    input  logic                     rd_rdy,
    output logic [WIDTH-1:0]         rd_dat,
    output logic [$clog2(DEPTH):0]   level
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_wr;
    logic             do_rd;

    assign wr_rdy = (level != (AW + 1)'(DEPTH));
    assign rd_vld = (level != '0);
    assign rd_dat = rd_vld ? mem[rd_ptr] : '0;
    assign do_wr  = wr_vld & wr_rdy;
    assign do_rd  = rd_vld & rd_rdy;

    // Pointers are exactly AW bits wide so they wrap modulo DEPTH on their own.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (do_wr) begin
                mem[wr_ptr] <= wr_dat;
                wr_ptr      <= wr_ptr + AW'(1);
            end
            if (do_rd) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({do_wr, do_rd})
                2'b10:   level <= level + (AW + 1)'(1);
                2'b01:   level <= level - (AW + 1)'(1);
                default: level <= level;
            endcase
        end
    end

endmodule

// File: tb/tb_button_event_queue.sv
// Directed bench for button_event_queue: short/long presses, arbitration, full FIFO, overflow, flush, ignored presses, async reset.
module tb_button_event_queue;
    localparam int NUM_BTN = 4;
    localparam int LPC     = 10;
    localparam int DEPTH   = 4;

    logic       clock = 1'b0;
    logic       reset = 1'b0;
    logic [3:0] btn_db = 4'b0000;
    logic       enable = 1'b1;
    logic       flush = 1'b0;
    logic       evt_ready = 1'b0;
    logic       evt_valid;
    logic [1:0] evt_btn;
    logic       evt_long;
    logic [2:0] fifo_level;
    logic       overflow;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clock = ~clock;

    button_event_queue #(
        .NUM_BTN           (NUM_BTN),
        .LONG_PRESS_CYCLES (LPC),
        .FIFO_DEPTH        (DEPTH)
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .btn_db     (btn_db),
        .enable     (enable),
        .flush      (flush),
        .evt_ready  (evt_ready),
        .evt_valid  (evt_valid),
        .evt_btn    (evt_btn),
        .evt_long   (evt_long),
        .fifo_level (fifo_level),
        .overflow   (overflow)
    );

    task automatic check(input string tag, input int got, input int exp);
        n_checks++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    endtask

    task automatic tick(input int n = 1);
        repeat (n) @(posedge clock);
        #1;
    endtask

    // Button high for n_high sampled edges, then one release edge (E0).
    task automatic press(input int idx, input int n_high);
        btn_db[idx] = 1'b1;
        tick(n_high);
        btn_db[idx] = 1'b0;
        tick(1);
    endtask

    task automatic pop();
        evt_ready = 1'b1;
        tick(1);
        evt_ready = 1'b0;
    endtask

    task automatic check_head(input string tag, input int v, input int b, input int l, input int lvl);
        check({tag, ".valid"}, evt_valid, v);
        check({tag, ".btn"},   evt_btn,   b);
        check({tag, ".long"},  evt_long,  l);
        check({tag, ".level"}, fifo_level, lvl);
    endtask

    initial begin
        // Reset state, with btn0 held through reset
        btn_db[0] = 1'b1;
        #2;
        check_head("reset", 0, 0, 0, 0);
        check("reset.ovf", overflow, 0);
        tick(2);
        reset = 1'b1;
        tick(3);
        btn_db[0] = 1'b0;
        tick(3);
        check_head("held_thru_reset", 0, 0, 0, 0);

        // Short press on btn1
        press(1, 3);
        check("short.e0_valid", evt_valid, 0);
        tick(1);
        check_head("short", 1, 1, 0, 1);
        pop();
        check_head("short_pop", 0, 0, 0, 0);

        // Long-press threshold
        press(2, 10);
        tick(1);
        check_head("long10", 1, 2, 1, 1);
        pop();
        press(2, 9);
        tick(1);
        check_head("long9", 1, 2, 0, 1);
        pop();
        press(2, 50);
        tick(1);
        check_head("long50", 1, 2, 1, 1);
        pop();
        check("long_pop.level", fifo_level, 0);

        // Simultaneous release of btn3 and btn0
        btn_db = 4'b1001;
        tick(3);
        btn_db = 4'b0000;
        tick(1);
        tick(1);
        check_head("simul1", 1, 0, 0, 1);
        tick(1);
        check_head("simul2", 1, 0, 0, 2);
        pop();
        check_head("simul_pop1", 1, 3, 0, 1);
        pop();
        check_head("simul_pop2", 0, 0, 0, 0);

        // Press while disabled is ignored
        enable = 1'b0;
        press(2, 3);
        tick(2);
        check_head("disabled", 0, 0, 0, 0);
        enable = 1'b1;

        // Full FIFO, pending hold, overflow, flush
        for (int k = 0; k < 5; k++) press(1, 2);
        tick(1);
        check_head("full", 1, 1, 0, 4);
        tick(4);
        check("full.hold_level", fifo_level, 4);
        check("full.no_ovf", overflow, 0);
        press(1, 2);
        check("ovf.set", overflow, 1);
        check("ovf.level", fifo_level, 4);
        pop();
        check("ovf.pop_level", fifo_level, 3);
        tick(1);
        check("ovf.refill_level", fifo_level, 4);
        check("ovf.sticky", overflow, 1);
        flush = 1'b1;
        tick(1);
        flush = 1'b0;
        check_head("flush", 0, 0, 0, 0);
        check("flush.ovf", overflow, 0);
        tick(2);
        check("flush.no_refill", fifo_level, 0);

        // Async reset with three queued events
        press(0, 2);
        press(1, 2);
        press(2, 2);
        tick(2);
        check_head("queue3", 1, 0, 0, 3);
        #3;
        reset = 1'b0;
        #1;
        check_head("async_rst", 0, 0, 0, 0);
        check("async_rst.ovf", overflow, 0);
        tick(1);
        reset = 1'b1;
        tick(2);
        check_head("post_rst", 0, 0, 0, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
